ball_motion_ctrl: RTL and testbench



---
 rtl/ball_motion_ctrl_if.sv | 27 ++
 rtl/ball_motion_ctrl.sv | 138 +++++++++++++
 tb/tb_ball_motion_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_ctrl_if.sv
// Bundle of frame-timing inputs and ball-state outputs shared between
// the motion sequencer and its consumers (renderer, sync generator).
interface ball_motion_ctrl_if;
   logic       vsync;
   logic       enable;
   logic       hit_h;
   logic       hit_v;
   logic [8:0] ball_hpos;
   logic [8:0] ball_vpos;
   logic [3:0] ball_hspeed;
   logic [3:0] ball_vspeed;
   logic       bounce_h;
   logic       bounce_v;
   logic       busy;

   modport master (
      output vsync, enable, hit_h, hit_v,
      input  ball_hpos, ball_vpos, ball_hspeed, ball_vspeed,
      input  bounce_h, bounce_v, busy
   );

   modport slave (
      input  vsync, enable, hit_h, hit_v,
      output ball_hpos, ball_vpos, ball_hspeed, ball_vspeed,
      output bounce_h, bounce_v, busy
   );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion sequencer: on each vsync rising edge apply latched
// collision reversals, then step X and Y with wall clamping and bounce.
module ball_motion_ctrl #(
   parameter int SCREEN_W  = 256,
   parameter int SCREEN_H  = 240,
   parameter int BALL_SIZE = 4,
   parameter int INIT_X    = 128,
   parameter int INIT_Y    = 128,
   parameter int INIT_VX   = 2,
   parameter int INIT_VY   = -2
) (
   input  logic               clk,
   input  logic               reset,
   ball_motion_ctrl_if.slave  bus
);
   localparam int XMAX = SCREEN_W - BALL_SIZE;
   localparam int YMAX = SCREEN_H - BALL_SIZE;

   typedef enum logic [1:0] {IDLE, HIT, MOVE_X, MOVE_Y} state_t;

   state_t      state_reg, state_next;
   logic        vsync_d_reg;
   logic        flag_h_reg, flag_h_next;
   logic        flag_v_reg, flag_v_next;
   logic [8:0]  hpos_reg, hpos_next;
   logic [8:0]  vpos_reg, vpos_next;
   logic [3:0]  hspeed_reg, hspeed_next;
   logic [3:0]  vspeed_reg, vspeed_next;
   logic        bounce_h_reg, bounce_h_next;
   logic        bounce_v_reg, bounce_v_next;
   logic        busy_reg, busy_next;
   logic        start;
   logic signed [9:0] sum_x, sum_y;

   // -8 has no positive 4-bit counterpart, so its reversal saturates to +7
   function automatic logic [3:0] neg_sat(input logic [3:0] s);
      return (s == 4'b1000) ? 4'b0111 : (~s + 4'd1);
   endfunction

   function automatic logic signed [9:0] step(input logic [8:0] pos, input logic [3:0] spd);
      return $signed({1'b0, pos}) + $signed({{6{spd[3]}}, spd});
   endfunction

   assign start = bus.vsync & ~vsync_d_reg;
   assign sum_x = step(hpos_reg, hspeed_reg);
   assign sum_y = step(vpos_reg, vspeed_reg);

   always_comb begin
      state_next    = state_reg;
      hpos_next     = hpos_reg;
      vpos_next     = vpos_reg;
      hspeed_next   = hspeed_reg;
      vspeed_next   = vspeed_reg;
      bounce_h_next = 1'b0;
      bounce_v_next = 1'b0;
      flag_h_next   = flag_h_reg | bus.hit_h;
      flag_v_next   = flag_v_reg | bus.hit_v;
      busy_next     = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            if (start && bus.enable) state_next = HIT;
         end
         HIT: begin
            if (flag_h_reg) hspeed_next = neg_sat(hspeed_reg);
            if (flag_v_reg) vspeed_next = neg_sat(vspeed_reg);
            // hits arriving in this very cycle belong to the next frame
            flag_h_next = bus.hit_h;
            flag_v_next = bus.hit_v;
            state_next  = MOVE_X;
         end
         MOVE_X: begin
            if (sum_x < 0) begin
               hpos_next     = '0;
               hspeed_next   = neg_sat(hspeed_reg);
               bounce_h_next = 1'b1;
            end else if (sum_x > $signed(10'(XMAX))) begin
               hpos_next     = 9'(XMAX);
               hspeed_next   = neg_sat(hspeed_reg);
               bounce_h_next = 1'b1;
            end else begin
               hpos_next = sum_x[8:0];
            end
            state_next = MOVE_Y;
         end
         MOVE_Y: begin
            if (sum_y < 0) begin
               vpos_next     = '0;
               vspeed_next   = neg_sat(vspeed_reg);
               bounce_v_next = 1'b1;
            end else if (sum_y > $signed(10'(YMAX))) begin
               vpos_next     = 9'(YMAX);
               vspeed_next   = neg_sat(vspeed_reg);
               bounce_v_next = 1'b1;
            end else begin
               vpos_next = sum_y[8:0];
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         vsync_d_reg  <= 1'b1;  // no spurious start if vsync is already high
         flag_h_reg   <= 1'b0;
         flag_v_reg   <= 1'b0;
         hpos_reg     <= 9'(INIT_X);
         vpos_reg     <= 9'(INIT_Y);
         hspeed_reg   <= 4'(INIT_VX);
         vspeed_reg   <= 4'(INIT_VY);
         bounce_h_reg <= 1'b0;
         bounce_v_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         vsync_d_reg  <= bus.vsync;
         flag_h_reg   <= flag_h_next;
         flag_v_reg   <= flag_v_next;
         hpos_reg     <= hpos_next;
         vpos_reg     <= vpos_next;
         hspeed_reg   <= hspeed_next;
         vspeed_reg   <= vspeed_next;
         bounce_h_reg <= bounce_h_next;
         bounce_v_reg <= bounce_v_next;
         busy_reg     <= busy_next;
      end
   end

   assign bus.ball_hpos   = hpos_reg;
   assign bus.ball_vpos   = vpos_reg;
   assign bus.ball_hspeed = hspeed_reg;
   assign bus.ball_vspeed = vspeed_reg;
   assign bus.bounce_h    = bounce_h_reg;
   assign bus.bounce_v    = bounce_v_reg;
   assign bus.busy        = busy_reg;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: frames push expected results,
// a negedge monitor pops and checks each completed update window.
module tb_ball_motion_ctrl;
   logic clk = 1'b0;
   logic reset;

   ball_motion_ctrl_if bus();

   ball_motion_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int h;
      int v;
      int hs;
      int vs;
      int bh;
      int bv;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_pushed = 0;
   int   frames_seen = 0;
   bit   abort_mon = 1'b0;

   bit   in_frame = 1'b0;
   int   k, bh_cnt, bv_cnt, bh_at, bv_at, h_at1, v_at2;
   exp_t e;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int h, input int v, input int hs, input int vs,
                               input int bh, input int bv);
      exp_t r;
      r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.bh = bh; r.bv = bv;
      return r;
   endfunction

   // Monitor: the update window is the run of busy cycles; results are final
   // once busy drops.
   always @(negedge clk) begin
      if (bus.busy) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            k = 0; bh_cnt = 0; bv_cnt = 0; bh_at = -1; bv_at = -1;
            h_at1 = -1; v_at2 = -1;
         end else begin
            k++;
         end
         if (k == 1) h_at1 = int'(bus.ball_hpos);
         if (k == 2) v_at2 = int'(bus.ball_vpos);
         if (bus.bounce_h) begin bh_cnt++; bh_at = k; end
         if (bus.bounce_v) begin bv_cnt++; bv_at = k; end
      end else begin
         if (bus.bounce_h || bus.bounce_v)
            check("bounce_outside_busy", int'(bus.bounce_h | bus.bounce_v), 0);
         if (in_frame) begin
            in_frame = 1'b0;
            if (!abort_mon) begin
               if (sb.size() == 0) begin
                  check("unexpected_frame", sb.size(), 1);
               end else begin
                  e = sb.pop_front();
                  frames_seen++;
                  check("busy_len", k + 1, 3);
                  check("hpos_at_E3", h_at1, e.h);
                  check("vpos_at_E4", v_at2, e.v);
                  check("hpos", int'(bus.ball_hpos), e.h);
                  check("vpos", int'(bus.ball_vpos), e.v);
                  check("hspeed", int'($signed(bus.ball_hspeed)), e.hs);
                  check("vspeed", int'($signed(bus.ball_vspeed)), e.vs);
                  check("bounce_h_count", bh_cnt, e.bh);
                  check("bounce_v_count", bv_cnt, e.bv);
                  if (e.bh != 0) check("bounce_h_cycle", bh_at, 1);
                  if (e.bv != 0) check("bounce_v_cycle", bv_at, 2);
                  $display("frame %0d: hpos=%0d vpos=%0d hspeed=%0d vspeed=%0d bh=%0d bv=%0d",
                           frames_seen, bus.ball_hpos, bus.ball_vpos,
                           $signed(bus.ball_hspeed), $signed(bus.ball_vspeed), bh_cnt, bv_cnt);
               end
            end
         end
      end
   end

   // One vsync frame; optionally pulses hit_h during the HIT cycle (E+1).
   task automatic frame(input bit push, input exp_t ex, input bit hit_in_hit);
      if (push) begin
         sb.push_back(ex);
         n_pushed++;
      end
      @(negedge clk); bus.vsync = 1'b0;
      repeat (2) @(negedge clk);
      bus.vsync = 1'b1;              // cycle E
      @(negedge clk);                // cycle E+1
      if (hit_in_hit) bus.hit_h = 1'b1;
      @(negedge clk);
      bus.hit_h = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic pulse_hit(input bit h, input bit v);
      @(negedge clk);
      bus.hit_h = h; bus.hit_v = v;
      @(negedge clk);
      bus.hit_h = 1'b0; bus.hit_v = 1'b0;
   endtask

   task automatic check_state(input string tag, input int h, input int v, input int hs, input int vs);
      check({tag, "_hpos"}, int'(bus.ball_hpos), h);
      check({tag, "_vpos"}, int'(bus.ball_vpos), v);
      check({tag, "_hspeed"}, int'($signed(bus.ball_hspeed)), hs);
      check({tag, "_vspeed"}, int'($signed(bus.ball_vspeed)), vs);
      check({tag, "_busy"}, int'(bus.busy), 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.vsync = 1'b1; bus.enable = 1'b1; bus.hit_h = 1'b0; bus.hit_v = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      // vsync held high across reset release must not start an update
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_state("reset", 128, 128, 2, -2);
      end
      check("reset_bounce", int'(bus.bounce_h | bus.bounce_v), 0);

      // Straight-line motion up to the exact right-wall position
      for (int n = 1; n <= 62; n++)
         frame(1'b1, mk(128 + 2 * n, 128 - 2 * n, 2, -2, 0, 0), 1'b0);
      frame(1'b1, mk(252, 2, -2, -2, 1, 0), 1'b0);   // right wall overshoot
      frame(1'b1, mk(250, 0, -2, -2, 0, 0), 1'b0);   // exactly top edge, no bounce
      frame(1'b1, mk(248, 0, -2, 2, 0, 1), 1'b0);    // top wall overshoot
      frame(1'b1, mk(246, 2, -2, 2, 0, 0), 1'b0);

      // Hit between frames: reversed once, then flag cleared
      pulse_hit(1'b1, 1'b0);
      frame(1'b1, mk(248, 4, 2, 2, 0, 0), 1'b0);
      frame(1'b1, mk(250, 6, 2, 2, 0, 0), 1'b0);

      // Hit during HIT cycle: current frame unaffected, next frame reverses
      frame(1'b1, mk(252, 8, 2, 2, 0, 0), 1'b1);
      frame(1'b1, mk(250, 10, -2, 2, 0, 0), 1'b0);

      // Paused frames with a vertical hit latched meanwhile
      bus.enable = 1'b0;
      pulse_hit(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) frame(1'b0, mk(0, 0, 0, 0, 0, 0), 1'b0);
      check_state("paused", 250, 10, -2, 2);
      bus.enable = 1'b1;
      frame(1'b1, mk(248, 8, -2, -2, 0, 0), 1'b0);
      frame(1'b1, mk(246, 6, -2, -2, 0, 0), 1'b0);

      // Reset in the middle of an update discards it
      abort_mon = 1'b1;
      @(negedge clk); bus.vsync = 1'b0;
      repeat (2) @(negedge clk);
      bus.vsync = 1'b1;              // E
      @(negedge clk);                // E+1
      @(negedge clk);                // E+2
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_state("midreset", 128, 128, 2, -2);
      repeat (4) @(negedge clk);
      check_state("after_midreset", 128, 128, 2, -2);
      abort_mon = 1'b0;
      frame(1'b1, mk(130, 126, 2, -2, 0, 0), 1'b0);

      repeat (4) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      check("frames_seen", frames_seen, n_pushed);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
